// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes,
// datapath select codes and the packed control word.
package mips_ctrl_pkg;

  localparam int unsigned StateW  = 4;
  localparam int unsigned OpcodeW = 6;
  localparam int unsigned SelW    = 2;

  typedef enum logic [StateW-1:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } stateT;

  localparam logic [OpcodeW-1:0] OpRType = 6'b000000;
  localparam logic [OpcodeW-1:0] OpLw    = 6'b100011;
  localparam logic [OpcodeW-1:0] OpSw    = 6'b101011;
  localparam logic [OpcodeW-1:0] OpBeq   = 6'b000100;
  localparam logic [OpcodeW-1:0] OpJ     = 6'b000010;
  localparam logic [OpcodeW-1:0] OpAddi  = 6'b001000;

  localparam logic [SelW-1:0] AluAdd   = 2'b00;
  localparam logic [SelW-1:0] AluSub   = 2'b01;
  localparam logic [SelW-1:0] AluFunct = 2'b10;

  localparam logic [SelW-1:0] SrcBReg   = 2'b00;
  localparam logic [SelW-1:0] SrcBFour  = 2'b01;
  localparam logic [SelW-1:0] SrcBImm   = 2'b10;
  localparam logic [SelW-1:0] SrcBImmSh = 2'b11;

  localparam logic [SelW-1:0] PcAlu    = 2'b00;
  localparam logic [SelW-1:0] PcAluOut = 2'b01;
  localparam logic [SelW-1:0] PcJump   = 2'b10;

  typedef struct packed {
    logic            pcWrite;
    logic            pcWriteCond;
    logic            iOrD;
    logic            memRead;
    logic            memWrite;
    logic            irWrite;
    logic            memToReg;
    logic            regDst;
    logic            regWrite;
    logic            aluSrcA;
    logic [SelW-1:0] aluSrcB;
    logic [SelW-1:0] aluOp;
    logic [SelW-1:0] pcSource;
    logic            instrDone;
    logic            illegalOp;
  } ctrlWord;

  localparam int unsigned CtrlW = $bits(ctrlWord);

  function automatic logic isLegalOp(input logic [OpcodeW-1:0] op);
    case (op)
      OpRType, OpLw, OpSw, OpBeq, OpJ, OpAddi: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_state_decode.sv
// Combinational state-to-control-word decode; every field defaults to 0 so
// unlisted outputs and undefined states drive nothing.
module mc_state_decode
  import mips_ctrl_pkg::*;
(
  input  logic [StateW-1:0]  state,
  input  logic               memReady,
  input  logic [OpcodeW-1:0] opcode,
  output logic [CtrlW-1:0]   ctrl
);

  ctrlWord cw;

  always_comb begin
    cw = '0;
    case (state)
      FETCH: begin
        cw.memRead = 1'b1;
        cw.aluSrcB = SrcBFour;
        cw.irWrite = memReady;
        cw.pcWrite = memReady;
      end
      DECODE: begin
        cw.aluSrcB   = SrcBImmSh;
        cw.illegalOp = !isLegalOp(opcode);
        cw.instrDone = !isLegalOp(opcode);
      end
      MEMADR, ADDIEX: begin
        cw.aluSrcA = 1'b1;
        cw.aluSrcB = SrcBImm;
      end
      MEMRD: begin
        cw.memRead = 1'b1;
        cw.iOrD    = 1'b1;
      end
      MEMWR: begin
        cw.memWrite  = 1'b1;
        cw.iOrD      = 1'b1;
        cw.instrDone = memReady;
      end
      MEMWB: begin
        cw.regWrite  = 1'b1;
        cw.memToReg  = 1'b1;
        cw.instrDone = 1'b1;
      end
      EXEC: begin
        cw.aluSrcA = 1'b1;
        cw.aluSrcB = SrcBReg;
        cw.aluOp   = AluFunct;
      end
      ALUWB: begin
        cw.regWrite  = 1'b1;
        cw.regDst    = 1'b1;
        cw.instrDone = 1'b1;
      end
      ADDIWB: begin
        cw.regWrite  = 1'b1;
        cw.instrDone = 1'b1;
      end
      BRANCH: begin
        cw.aluSrcA     = 1'b1;
        cw.aluSrcB     = SrcBReg;
        cw.aluOp       = AluSub;
        cw.pcWriteCond = 1'b1;
        cw.pcSource    = PcAluOut;
        cw.instrDone   = 1'b1;
      end
      JUMP: begin
        cw.pcWrite   = 1'b1;
        cw.pcSource  = PcJump;
        cw.instrDone = 1'b1;
      end
      default: cw = '0;
    endcase
  end

  assign ctrl = cw;

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state register and next-state logic here,
// control word from mc_state_decode, all controls forced to 0 during reset.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemToReg,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  PCSource,
  output logic [3:0]  state,
  output logic        instr_done,
  output logic        illegal_op
);

  logic [StateW-1:0] stateQ;
  logic [CtrlW-1:0]  decBits;
  ctrlWord           cw;

  // Opcode is only looked at in DECODE and MEMADR; anything unrecognised falls back to FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= FETCH;
    end else begin
      case (stateQ)
        FETCH:  if (mem_ready) stateQ <= DECODE;
        DECODE: begin
          case (opcode)
            OpRType:    stateQ <= EXEC;
            OpLw, OpSw: stateQ <= MEMADR;
            OpBeq:      stateQ <= BRANCH;
            OpJ:        stateQ <= JUMP;
            OpAddi:     stateQ <= ADDIEX;
            default:    stateQ <= FETCH;
          endcase
        end
        MEMADR: stateQ <= (opcode == OpSw) ? MEMWR : MEMRD;
        MEMRD:  if (mem_ready) stateQ <= MEMWB;
        MEMWR:  if (mem_ready) stateQ <= FETCH;
        EXEC:   stateQ <= ALUWB;
        ADDIEX: stateQ <= ADDIWB;
        default: stateQ <= FETCH;
      endcase
    end
  end

  mc_state_decode uDecode (
    .state    (stateQ),
    .memReady (mem_ready),
    .opcode   (opcode),
    .ctrl     (decBits)
  );

  assign cw = rst ? '0 : ctrlWord'(decBits);

  assign PCWrite     = cw.pcWrite;
  assign PCWriteCond = cw.pcWriteCond;
  assign IorD        = cw.iOrD;
  assign MemRead     = cw.memRead;
  assign MemWrite    = cw.memWrite;
  assign IRWrite     = cw.irWrite;
  assign MemToReg    = cw.memToReg;
  assign RegDst      = cw.regDst;
  assign RegWrite    = cw.regWrite;
  assign ALUSrcA     = cw.aluSrcA;
  assign ALUSrcB     = cw.aluSrcB;
  assign ALUOp       = cw.aluOp;
  assign PCSource    = cw.pcSource;
  assign instr_done  = cw.instrDone;
  assign illegal_op  = cw.illegalOp;
  assign state       = stateQ;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle vector table through a scoreboard
// queue, then whole-instruction latency/write-count sequences.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemToReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;
  logic       instr_done, illegal_op;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state(state), .instr_done(instr_done),
    .illegal_op(illegal_op)
  );

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] JMP = 6'b000010, RT = 6'b000000, ADDI = 6'b001000;
  localparam logic [5:0] BAD = 6'b111111, JAL = 6'b000011;

  // en order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemToReg RegDst RegWrite ALUSrcA
  typedef struct packed {
    logic       rst;
    logic [5:0] op;
    logic       mr;
    logic [3:0] st;
    logic [9:0] en;
    logic [1:0] srcB;
    logic [1:0] aluOp;
    logic [1:0] pcSrc;
    logic       done;
    logic       ill;
  } vecT;

  typedef struct {
    int lat;
    int rw;
    int mw;
  } expT;

  vecT vecs[$];
  vecT expQ[$];
  expT instrQ[$];
  int  checks = 0;
  int  failures = 0;

  function automatic logic [21:0] obsWord();
    return {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
            MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
            instr_done, illegal_op};
  endfunction

  task automatic add(input logic r, input logic [5:0] op, input logic mr,
                     input logic [3:0] st, input logic [9:0] en,
                     input logic [1:0] sb, input logic [1:0] ao,
                     input logic [1:0] ps, input logic d, input logic il);
    vecs.push_back(vecT'{r, op, mr, st, en, sb, ao, ps, d, il});
  endtask

  task automatic runInstr(input logic [5:0] op, input int fw, input int mw,
                          input int lat, input int rw, input int mwc);
    int  k = 0;
    int  nRw = 0;
    int  nMw = 0;
    bit  seen = 1'b0;
    expT e;
    instrQ.push_back('{lat, rw, mwc});
    opcode = op;
    while (!seen && k < 40) begin
      mem_ready = !(k < fw) && !(k >= fw + 3 && k < fw + 3 + mw);
      @(negedge clk);
      nRw += int'(RegWrite);
      nMw += int'(MemWrite);
      k++;
      if (instr_done) seen = 1'b1;
      @(posedge clk); #1;
    end
    e = instrQ.pop_front();
    checks++;
    if (!seen || k != e.lat || nRw != e.rw || nMw != e.mw) begin
      failures++;
      $display("FAIL instr op=%b fw=%0d mw=%0d: done=%0d cycles=%0d regWrites=%0d memWrites=%0d, required cycles=%0d regWrites=%0d memWrites=%0d",
               op, fw, mw, seen, k, nRw, nMw, e.lat, e.rw, e.mw);
    end
  endtask

  initial begin
    vecT v, e;
    logic [21:0] got, req;
    logic [5:0] ops [7];
    rst = 1'b1; opcode = 6'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // lw, no waits (reset cycle first)
    add(1, LW, 1, 0, 10'b0000000000, 2'b00, 2'b00, 2'b00, 0, 0);
    add(0, LW, 1, 0, 10'b1001010000, 2'b01, 2'b00, 2'b00, 0, 0);
    add(0, LW, 1, 1, 10'b0000000000, 2'b11, 2'b00, 2'b00, 0, 0);
    add(0, LW, 1, 2, 10'b0000000001, 2'b10, 2'b00, 2'b00, 0, 0);
    add(0, LW, 1, 3, 10'b0011000000, 2'b00, 2'b00, 2'b00, 0, 0);
    add(0, LW, 1, 4, 10'b0000001010, 2'b00, 2'b00, 2'b00, 1, 0);
    // sw with three wait cycles in MEMWR
    add(0, SW, 1, 0, 10'b1001010000, 2'b01, 2'b00, 2'b00, 0, 0);
    add(0, SW, 1, 1, 10'b0000000000, 2'b11, 2'b00, 2'b00, 0, 0);
    add(0, SW, 1, 2, 10'b0000000001, 2'b10, 2'b00, 2'b00, 0, 0);
    add(0, SW, 0, 5, 10'b0010100000, 2'b00, 2'b00, 2'b00, 0, 0);
    add(0, SW, 0, 5, 10'b0010100000, 2'b00, 2'b00, 2'b00, 0, 0);
    add(0, SW, 0, 5, 10'b0010100000, 2'b00, 2'b00, 2'b00, 0, 0);
    add(0, SW, 1, 5, 10'b0010100000, 2'b00, 2'b00, 2'b00, 1, 0);
    // beq
    add(0, BEQ, 1, 0, 10'b1001010000, 2'b01, 2'b00, 2'b00, 0, 0);
    add(0, BEQ, 1, 1, 10'b0000000000, 2'b11, 2'b00, 2'b00, 0, 0);
    add(0, BEQ, 1, 8, 10'b0100000001, 2'b00, 2'b01, 2'b01, 1, 0);
    // illegal opcode
    add(0, BAD, 1, 0, 10'b1001010000, 2'b01, 2'b00, 2'b00, 0, 0);
    add(0, BAD, 1, 1, 10'b0000000000, 2'b11, 2'b00, 2'b00, 1, 1);
    // R-type (opcode changed during EXEC), addi, j back-to-back
    add(0, RT, 1, 0, 10'b1001010000, 2'b01, 2'b00, 2'b00, 0, 0);
    add(0, RT, 1, 1, 10'b0000000000, 2'b11, 2'b00, 2'b00, 0, 0);
    add(0, SW, 1, 6, 10'b0000000001, 2'b00, 2'b10, 2'b00, 0, 0);
    add(0, RT, 1, 7, 10'b0000000110, 2'b00, 2'b00, 2'b00, 1, 0);
    add(0, ADDI, 1, 0, 10'b1001010000, 2'b01, 2'b00, 2'b00, 0, 0);
    add(0, ADDI, 1, 1, 10'b0000000000, 2'b11, 2'b00, 2'b00, 0, 0);
    add(0, ADDI, 1, 10, 10'b0000000001, 2'b10, 2'b00, 2'b00, 0, 0);
    add(0, ADDI, 1, 11, 10'b0000000010, 2'b00, 2'b00, 2'b00, 1, 0);
    add(0, JMP, 1, 0, 10'b1001010000, 2'b01, 2'b00, 2'b00, 0, 0);
    add(0, JMP, 1, 1, 10'b0000000000, 2'b11, 2'b00, 2'b00, 0, 0);
    add(0, JMP, 1, 9, 10'b1000000000, 2'b00, 2'b00, 2'b10, 1, 0);
    // fetch wait, lw waiting in MEMRD, reset mid-wait
    add(0, LW, 0, 0, 10'b0001000000, 2'b01, 2'b00, 2'b00, 0, 0);
    add(0, LW, 1, 0, 10'b1001010000, 2'b01, 2'b00, 2'b00, 0, 0);
    add(0, LW, 1, 1, 10'b0000000000, 2'b11, 2'b00, 2'b00, 0, 0);
    add(0, LW, 1, 2, 10'b0000000001, 2'b10, 2'b00, 2'b00, 0, 0);
    add(0, BAD, 0, 3, 10'b0011000000, 2'b00, 2'b00, 2'b00, 0, 0);
    add(0, BEQ, 0, 3, 10'b0011000000, 2'b00, 2'b00, 2'b00, 0, 0);
    add(1, LW, 0, 3, 10'b0000000000, 2'b00, 2'b00, 2'b00, 0, 0);
    add(0, LW, 1, 0, 10'b1001010000, 2'b01, 2'b00, 2'b00, 0, 0);
    add(0, SW, 1, 1, 10'b0000000000, 2'b11, 2'b00, 2'b00, 0, 0);
    add(0, SW, 1, 2, 10'b0000000001, 2'b10, 2'b00, 2'b00, 0, 0);
    add(0, SW, 1, 5, 10'b0010100000, 2'b00, 2'b00, 2'b00, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      rst = v.rst; opcode = v.op; mem_ready = v.mr;
      expQ.push_back(v);
      @(negedge clk);
      e = expQ.pop_front();
      got = obsWord();
      req = {e.st, e.en, e.srcB, e.aluOp, e.pcSrc, e.done, e.ill};
      checks++;
      if (got !== req) begin
        failures++;
        $display("FAIL vec[%0d]: got st=%0d ctrl=%b, required st=%0d ctrl=%b",
                 i, got[21:18], got[17:0], req[21:18], req[17:0]);
      end
      @(posedge clk); #1;
    end

    // Whole-instruction latency and write counts, with memory waits
    runInstr(LW,   0, 0, 5,  1, 0);
    runInstr(LW,   2, 3, 10, 1, 0);
    runInstr(SW,   1, 2, 7,  0, 3);
    runInstr(BEQ,  3, 0, 6,  0, 0);
    runInstr(JMP,  0, 0, 3,  0, 0);
    runInstr(RT,   1, 0, 5,  1, 0);
    runInstr(ADDI, 0, 0, 4,  1, 0);
    runInstr(BAD,  2, 0, 4,  0, 0);
    runInstr(JAL,  0, 0, 2,  0, 0);

    ops = '{LW, SW, BEQ, JMP, RT, ADDI, BAD};
    for (int n = 0; n < 10; n++) begin
      int sel = int'($urandom_range(0, 6));
      int fw  = int'($urandom_range(0, 3));
      int mw  = int'($urandom_range(0, 3));
      case (ops[sel])
        LW:       runInstr(ops[sel], fw, mw, 5 + fw + mw, 1, 0);
        SW:       runInstr(ops[sel], fw, mw, 4 + fw + mw, 0, mw + 1);
        BEQ, JMP: runInstr(ops[sel], fw, mw, 3 + fw, 0, 0);
        RT, ADDI: runInstr(ops[sel], fw, mw, 4 + fw, 1, 0);
        default:  runInstr(ops[sel], fw, mw, 2 + fw, 0, 0);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port opcode, input, 6 bits: instruction bits [31:26], valid from the instruction register.
REQ-004 SHALL have port mem_ready, input, 1 bit: memory has completed the current read or write this cycle.
REQ-005 SHALL have ports PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite and ALUSrcA, all output, 1 bit each: datapath enables and 2:1 mux selects.
REQ-006 SHALL have ports ALUSrcB, ALUOp and PCSource, all output, 2 bits each: ALU B select (00 reg, 01 const 4, 10 sign-extended immediate, 11 immediate<<2), ALU op class (00 add, 01 sub, 10 funct), and next-PC select (00 ALU, 01 ALUOut, 10 jump target).
REQ-007 SHALL have port state, output, 4 bits: current FSM state, for debug.
REQ-008 SHALL have port instr_done, output, 1 bit: one-cycle pulse in the last cycle of every instruction.
REQ-009 SHALL have port illegal_op, output, 1 bit: one-cycle pulse in DECODE when the opcode is unsupported.

Function
REQ-010 SHALL implement a Moore FSM with 12 states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
REQ-011 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00 and PCSource=00; IRWrite and PCWrite SHALL be 1 only in the cycle where mem_ready=1.
REQ-012 FETCH SHALL hold while mem_ready=0 and go to DECODE on mem_ready=1.
REQ-013 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11 and ALUOp=00 (branch target into ALUOut).
REQ-014 DECODE SHALL go to EXEC for opcode 000000, MEMADR for 100011 or 101011, BRANCH for 000100, JUMP for 000010 and ADDIEX for 001000.
REQ-015 DECODE SHALL go to FETCH for any other opcode, pulsing illegal_op and instr_done, with no writes.
REQ-016 MEMADR and ADDIEX SHALL drive ALUSrcA=1, ALUSrcB=10 and ALUOp=00; MEMADR SHALL go to MEMRD for lw and MEMWR for sw; ADDIEX SHALL go to ADDIWB.
REQ-017 MEMRD SHALL drive MemRead=1 and IorD=1, holding until mem_ready=1, then going to MEMWB.
REQ-018 MEMWR SHALL drive MemWrite=1 and IorD=1, holding until mem_ready=1; on exit it SHALL pulse instr_done and go to FETCH.
REQ-019 MEMWB SHALL drive RegWrite=1, MemToReg=1 and RegDst=0.
REQ-020 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00 and ALUOp=10.
REQ-021 ALUWB SHALL drive RegWrite=1, MemToReg=0 and RegDst=1.
REQ-022 ADDIWB SHALL drive RegWrite=1, MemToReg=0 and RegDst=0.
REQ-023 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1 and PCSource=01.
REQ-024 JUMP SHALL drive PCWrite=1 and PCSource=10.
REQ-025 MEMWB, ALUWB, ADDIWB, BRANCH and JUMP SHALL each last one cycle, pulse instr_done and return to FETCH.
REQ-026 Every output not listed for a state SHALL be 0; no x values SHALL be driven in any state.
REQ-027 Latency with mem_ready tied to 1 SHALL be: beq/j 3 cycles, R-type/addi/sw 4 cycles, lw 5 cycles; each memory wait cycle SHALL add exactly 1.
REQ-028 opcode SHALL be sampled only in DECODE and MEMADR; changes elsewhere SHALL have no effect.
REQ-029 An undefined state encoding (12-15) SHALL go to FETCH on the next edge with all enables 0.

Reset
REQ-030 rst=1 at a clock edge SHALL set state to FETCH, overriding any transition, including mid-wait in MEMRD or MEMWR.
REQ-031 While rst=1, PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, instr_done and illegal_op SHALL be 0, and all selects SHALL be 0.
REQ-032 The first cycle after rst is released SHALL be FETCH with MemRead=1.

Structure
REQ-033 Opcode constants, state encodings, ALUOp codes and ALUSrcB/PCSource codes SHALL live in shared package mips_ctrl_pkg.
REQ-034 The state-to-control-word decode SHALL be one combinational sub-module, mc_state_decode; the next-state logic and state register SHALL stay in multicycle_control.

Verification
REQ-035 Reset, then lw (100011) with mem_ready=1 -> states 0,1,2,3,4; RegWrite=1 and MemToReg=1 only in state 4; instr_done at cycle 5.
REQ-036 sw (101011) with mem_ready low for 3 cycles in MEMWR -> MemWrite held for 4 cycles, RegWrite never 1, total 7 cycles.
REQ-037 beq (000100) -> states 0,1,8; PCWriteCond=1, ALUOp=01 and PCSource=01 in state 8 only.
REQ-038 Opcode 111111 -> states 0,1,0; illegal_op=1 for 1 cycle; no write enable asserted.
REQ-039 rst asserted in MEMRD during a wait -> next state 0, MemRead=0 while rst=1, then a normal fetch.
REQ-040 Back-to-back R-type (000000), addi (001000), j (000010) -> 4+4+3 cycles, three instr_done pulses, RegDst=1 only in ALUWB.
